// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch: mode encoding and timebase derivations.
// The derivation functions are also used by the digit-counter bench.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_LAP   = 2'd3
   } sw_state_t;

   function automatic int calc_div(input int clk_hz, input int tick_hz);
      return clk_hz / tick_hz;
   endfunction

   function automatic int calc_db_cycles(input int clk_hz, input int debounce_ms);
      return clk_hz / 1000 * debounce_ms;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus counting debouncer for one active-low push-button.
// press fires once per debounced 1->0 change; a key held across reset stays silent until released.
module key_debounce #(
   parameter int DB_CYCLES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic level,
   output logic press
);

   localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic          sync1_r;
   logic          sync2_r;
   logic          level_r;
   logic          press_r;
   logic          armed_r;
   logic [1:0]    fill_r;
   logic [CW-1:0] cnt_r;

   // Synchronizer; arming waits until the first genuine post-reset sample shows the key released
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
         fill_r  <= 2'd0;
         armed_r <= 1'b0;
      end else begin
         sync1_r <= key_n;
         sync2_r <= sync1_r;
         if (fill_r != 2'd2) begin
            fill_r <= fill_r + 2'd1;
         end
         if ((fill_r == 2'd2) && sync2_r) begin
            armed_r <= 1'b1;
         end
      end
   end

   // Level follows the synchronized key after DB_CYCLES consecutive mismatching samples
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level_r <= 1'b1;
         press_r <= 1'b0;
         cnt_r   <= {CW{1'b0}};
      end else begin
         press_r <= 1'b0;
         if (sync2_r == level_r) begin
            cnt_r <= {CW{1'b0}};
         end else if (cnt_r == CNT_LAST) begin
            cnt_r   <= {CW{1'b0}};
            level_r <= sync2_r;
            press_r <= armed_r & ~sync2_r;
         end else begin
            cnt_r <= cnt_r + CW'(1);
         end
      end
   end

   assign level = level_r;
   assign press = press_r;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced keys, IDLE/RUN/PAUSE/LAP mode FSM and the 0.1 s tick prescaler.
// Outputs drive the digit counters (run, tick, clear) and the segment decoders (freeze).
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int CLK_HZ      = 50_000_000,
   parameter int TICK_HZ     = 10,
   parameter int DEBOUNCE_MS = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_start_n,
   input  logic       key_lap_n,
   output logic       run,
   output logic       tick,
   output logic       clear,
   output logic       freeze,
   output logic [1:0] state
);

   localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
   localparam int DBC = calc_db_cycles(CLK_HZ, DEBOUNCE_MS);
   localparam int PW  = $clog2(DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

   sw_state_t     state_r;
   logic          run_r;
   logic          tick_r;
   logic          clear_r;
   logic          freeze_r;
   logic [PW-1:0] presc_r;
   logic [PW-1:0] presc_inc_s;
   logic [PW-1:0] presc_adv_s;
   logic          adv_last_s;
   logic          start_press_s;
   logic          lap_press_s;
   logic          start_level_s;
   logic          lap_level_s;
   logic          unused_levels_s;

   key_debounce #(.DB_CYCLES(DBC)) u_start_db (
      .clk   (clk),
      .reset (reset),
      .key_n (key_start_n),
      .level (start_level_s),
      .press (start_press_s)
   );

   key_debounce #(.DB_CYCLES(DBC)) u_lap_db (
      .clk   (clk),
      .reset (reset),
      .key_n (key_lap_n),
      .level (lap_level_s),
      .press (lap_press_s)
   );

   assign unused_levels_s = start_level_s ^ lap_level_s;

   // Next prescaler value: advances only while running, wrapping after DIV-1
   always_comb begin
      if (presc_r == PRESC_LAST) begin
         presc_inc_s = {PW{1'b0}};
      end else begin
         presc_inc_s = presc_r + PW'(1);
      end
      if (run_r) begin
         presc_adv_s = presc_inc_s;
      end else begin
         presc_adv_s = presc_r;
      end
      adv_last_s = (presc_adv_s == PRESC_LAST);
   end

   // Mode FSM; start outranks lap when both arrive together
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r  <= ST_IDLE;
         run_r    <= 1'b0;
         tick_r   <= 1'b0;
         clear_r  <= 1'b0;
         freeze_r <= 1'b0;
         presc_r  <= {PW{1'b0}};
      end else begin
         presc_r <= presc_adv_s;
         tick_r  <= run_r & adv_last_s;
         clear_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start_press_s) begin
                  state_r <= ST_RUN;
                  run_r   <= 1'b1;
                  tick_r  <= adv_last_s;
               end
            end
            ST_RUN: begin
               if (start_press_s) begin
                  state_r <= ST_PAUSE;
                  run_r   <= 1'b0;
                  tick_r  <= 1'b0;
               end else if (lap_press_s) begin
                  state_r  <= ST_LAP;
                  freeze_r <= 1'b1;
               end
            end
            ST_LAP: begin
               if (start_press_s) begin
                  state_r  <= ST_PAUSE;
                  run_r    <= 1'b0;
                  tick_r   <= 1'b0;
                  freeze_r <= 1'b0;
               end else if (lap_press_s) begin
                  state_r  <= ST_RUN;
                  freeze_r <= 1'b0;
               end
            end
            ST_PAUSE: begin
               if (start_press_s) begin
                  state_r <= ST_RUN;
                  run_r   <= 1'b1;
                  tick_r  <= adv_last_s;
               end else if (lap_press_s) begin
                  state_r <= ST_IDLE;
                  clear_r <= 1'b1;
                  presc_r <= {PW{1'b0}};
               end
            end
            default: begin
               state_r  <= ST_IDLE;
               run_r    <= 1'b0;
               tick_r   <= 1'b0;
               freeze_r <= 1'b0;
               presc_r  <= {PW{1'b0}};
            end
         endcase
      end
   end

   assign run    = run_r;
   assign tick   = tick_r;
   assign clear  = clear_r;
   assign freeze = freeze_r;
   assign state  = state_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with CLK_HZ=1000, TICK_HZ=10, DEBOUNCE_MS=2 (DIV=100, DB_CYCLES=2).
module tb_stopwatch_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       key_start_n;
   logic       key_lap_n;
   logic       run;
   logic       tick;
   logic       clear;
   logic       freeze;
   logic [1:0] state;

   int n_vec = 0;
   int n_err = 0;

   stopwatch_ctrl #(
      .CLK_HZ      (1000),
      .TICK_HZ     (10),
      .DEBOUNCE_MS (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .key_start_n (key_start_n),
      .key_lap_n   (key_lap_n),
      .run         (run),
      .tick        (tick),
      .clear       (clear),
      .freeze      (freeze),
      .state       (state)
   );

   always #5 clk = ~clk;

   // advance one rising edge and settle before sampling / driving
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      key_start_n = 1'b1;
      key_lap_n = 1'b1;
      step();
      step();
      n_vec++;
      if (state !== 2'd0) begin n_err++; $display("FAIL reset_state got=%0d exp=0", state); end
      n_vec++;
      if ({run, tick, clear, freeze} !== 4'b0000) begin
         n_err++; $display("FAIL reset_outputs got=%b exp=0000", {run, tick, clear, freeze});
      end
      reset = 1'b0;
      repeat (5) step();
      n_vec++;
      if (state !== 2'd0 || run !== 1'b0) begin n_err++; $display("FAIL idle_after_reset state=%0d run=%0d exp 0/0", state, run); end
   endtask

   task automatic test_start();
      key_start_n = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         step();
         n_vec++;
         if (state !== 2'd0) begin n_err++; $display("FAIL start_latency edge %0d state=%0d exp=0", e, state); end
      end
      step();
      n_vec++;
      if (state !== 2'd1) begin n_err++; $display("FAIL start_enter state=%0d exp=1", state); end
      n_vec++;
      if (run !== 1'b1 || freeze !== 1'b0 || tick !== 1'b0) begin
         n_err++; $display("FAIL start_outputs run=%0d freeze=%0d tick=%0d exp 1/0/0", run, freeze, tick);
      end
      for (int i = 1; i <= 110; i++) begin
         step();
         if (i == 5) key_start_n = 1'b1;
         n_vec++;
         if (tick !== ((i == 99) ? 1'b1 : 1'b0)) begin n_err++; $display("FAIL first_tick run cycle %0d tick=%0d", i, tick); end
      end
   endtask

   task automatic test_glitch();
      for (int i = 111; i <= 245; i++) begin
         step();
         if (i == 120) key_start_n = 1'b0;
         if (i == 121) key_start_n = 1'b1;
         n_vec++;
         if (tick !== ((i == 199) ? 1'b1 : 1'b0) || state !== 2'd1) begin
            n_err++; $display("FAIL glitch run cycle %0d tick=%0d state=%0d", i, tick, state);
         end
      end
   endtask

   task automatic test_pause();
      key_start_n = 1'b0;
      for (int i = 246; i <= 249; i++) begin
         step();
         n_vec++;
         if (state !== 2'd1 || tick !== 1'b0) begin n_err++; $display("FAIL pause_latency cycle %0d state=%0d tick=%0d", i, state, tick); end
      end
      step();
      n_vec++;
      if (state !== 2'd2 || run !== 1'b0 || freeze !== 1'b0) begin
         n_err++; $display("FAIL pause_enter state=%0d run=%0d freeze=%0d exp 2/0/0", state, run, freeze);
      end
      key_start_n = 1'b1;
      for (int p = 1; p <= 500; p++) begin
         step();
         n_vec++;
         if (tick !== 1'b0 || state !== 2'd2) begin n_err++; $display("FAIL paused cycle %0d tick=%0d state=%0d", p, tick, state); end
      end
      key_start_n = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         step();
         n_vec++;
         if (state !== 2'd2) begin n_err++; $display("FAIL resume_latency edge %0d state=%0d exp=2", e, state); end
      end
      step();
      n_vec++;
      if (state !== 2'd1 || run !== 1'b1) begin n_err++; $display("FAIL resume_enter state=%0d run=%0d exp 1/1", state, run); end
      key_start_n = 1'b1;
      for (int k = 1; k <= 160; k++) begin
         step();
         n_vec++;
         if (tick !== ((k == 49 || k == 149) ? 1'b1 : 1'b0)) begin n_err++; $display("FAIL resume_tick cycle %0d tick=%0d", k, tick); end
      end
   endtask

   task automatic test_lap();
      key_lap_n = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         step();
         n_vec++;
         if (state !== 2'd1) begin n_err++; $display("FAIL lap_latency edge %0d state=%0d exp=1", e, state); end
      end
      step();
      n_vec++;
      if (state !== 2'd3 || freeze !== 1'b1 || run !== 1'b1) begin
         n_err++; $display("FAIL lap_enter state=%0d freeze=%0d run=%0d exp 3/1/1", state, freeze, run);
      end
      key_lap_n = 1'b1;
      for (int j = 1; j <= 100; j++) begin
         step();
         n_vec++;
         if (tick !== ((j == 84) ? 1'b1 : 1'b0) || freeze !== 1'b1 || state !== 2'd3) begin
            n_err++; $display("FAIL lap_hold cycle %0d tick=%0d freeze=%0d state=%0d", j, tick, freeze, state);
         end
      end
      key_lap_n = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         step();
         n_vec++;
         if (state !== 2'd3) begin n_err++; $display("FAIL unlap_latency edge %0d state=%0d exp=3", e, state); end
      end
      step();
      n_vec++;
      if (state !== 2'd1 || freeze !== 1'b0 || run !== 1'b1) begin
         n_err++; $display("FAIL unlap_enter state=%0d freeze=%0d run=%0d exp 1/0/1", state, freeze, run);
      end
      key_lap_n = 1'b1;
   endtask

   task automatic test_clear();
      repeat (10) step();
      key_start_n = 1'b0;
      repeat (5) step();
      n_vec++;
      if (state !== 2'd2) begin n_err++; $display("FAIL clear_prep_pause state=%0d exp=2", state); end
      key_start_n = 1'b1;
      repeat (10) step();
      key_lap_n = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         step();
         n_vec++;
         if (state !== 2'd2 || clear !== 1'b0) begin n_err++; $display("FAIL clear_latency edge %0d state=%0d clear=%0d", e, state, clear); end
      end
      step();
      n_vec++;
      if (state !== 2'd0 || clear !== 1'b1 || run !== 1'b0 || freeze !== 1'b0) begin
         n_err++; $display("FAIL clear_enter state=%0d clear=%0d run=%0d freeze=%0d exp 0/1/0/0", state, clear, run, freeze);
      end
      step();
      n_vec++;
      if (clear !== 1'b0 || state !== 2'd0) begin n_err++; $display("FAIL clear_width clear=%0d state=%0d exp 0/0", clear, state); end
      key_lap_n = 1'b1;
      repeat (10) step();
      key_start_n = 1'b0;
      repeat (5) step();
      n_vec++;
      if (state !== 2'd1) begin n_err++; $display("FAIL restart_enter state=%0d exp=1", state); end
      key_start_n = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         step();
         n_vec++;
         if (tick !== ((k == 99) ? 1'b1 : 1'b0)) begin n_err++; $display("FAIL restart_tick cycle %0d tick=%0d", k, tick); end
      end
   endtask

   task automatic test_both();
      repeat (10) step();
      key_start_n = 1'b0;
      key_lap_n = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         step();
         n_vec++;
         if (state !== 2'd1) begin n_err++; $display("FAIL both_latency edge %0d state=%0d exp=1", e, state); end
      end
      step();
      n_vec++;
      if (state !== 2'd2 || freeze !== 1'b0) begin n_err++; $display("FAIL both_keys state=%0d freeze=%0d exp 2/0", state, freeze); end
      key_start_n = 1'b1;
      key_lap_n = 1'b1;
      repeat (10) step();
      n_vec++;
      if (state !== 2'd2) begin n_err++; $display("FAIL both_settle state=%0d exp=2", state); end
   endtask

   task automatic test_reset_mid();
      key_start_n = 1'b0;
      repeat (5) step();
      n_vec++;
      if (state !== 2'd1) begin n_err++; $display("FAIL mid_prep_run state=%0d exp=1", state); end
      key_start_n = 1'b1;
      repeat (10) step();
      key_start_n = 1'b0;
      key_lap_n = 1'b0;
      repeat (3) step();
      reset = 1'b1;
      #2;
      n_vec++;
      if (state !== 2'd0) begin n_err++; $display("FAIL mid_reset_state state=%0d exp=0", state); end
      n_vec++;
      if ({run, tick, clear, freeze} !== 4'b0000) begin
         n_err++; $display("FAIL mid_reset_outputs got=%b exp=0000", {run, tick, clear, freeze});
      end
      step();
      step();
      reset = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         step();
         n_vec++;
         if (state !== 2'd0 || run !== 1'b0) begin n_err++; $display("FAIL held_through_reset cycle %0d state=%0d run=%0d", i, state, run); end
      end
      key_start_n = 1'b1;
      key_lap_n = 1'b1;
      repeat (10) step();
      key_start_n = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         step();
         n_vec++;
         if (state !== 2'd0) begin n_err++; $display("FAIL repress_latency edge %0d state=%0d exp=0", e, state); end
      end
      step();
      n_vec++;
      if (state !== 2'd1 || run !== 1'b1) begin n_err++; $display("FAIL repress_enter state=%0d run=%0d exp 1/1", state, run); end
      key_start_n = 1'b1;
   endtask

   initial begin
      reset = 1'b1;
      key_start_n = 1'b1;
      key_lap_n = 1'b1;
      test_reset();
      test_start();
      test_glitch();
      test_pause();
      test_lap();
      test_clear();
      test_both();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control and timebase block for the seven-segment stopwatch. Debounces the two board push-buttons (START/STOP and LAP/CLEAR) and runs the stopwatch mode FSM. Generates the 0.1 s count-enable tick plus the clear and display-freeze controls that drive the digit counters and segment decoders. Sits between the board keys and the counter/decoder datapath; the datapath has no prescaler of its own once this block is in place.

## Interface

Parameters:
- CLK_HZ, 50_000_000, input clock frequency in Hz.
- TICK_HZ, 10, tick rate in Hz; DIV = CLK_HZ/TICK_HZ. Must divide exactly and be ≥ 2.
- DEBOUNCE_MS, 20, debounce window in ms; DB_CYCLES = CLK_HZ/1000*DEBOUNCE_MS. Must be ≥ 1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- key_start_n  in  1  START/STOP button, active-low, asynchronous to clk.
- key_lap_n  in  1  LAP/CLEAR button, active-low, asynchronous to clk.
- run  out  1  high in RUN and LAP; counters may advance.
- tick  out  1  one-cycle count enable, every DIV cycles while run.
- clear  out  1  one-cycle pulse; zero all digit counters.
- freeze  out  1  high in LAP; decoders hold the displayed value while counting continues.
- state  out  2  IDLE=0, RUN=1, PAUSE=2, LAP=3.

## Operation

- Each key passes through a 2-flop synchronizer, then a debouncer. The debounced level changes only after the synchronized input differs from it for DB_CYCLES consecutive cycles. Any mismatch-free sample (input equals level) restarts the count.
- Press event: a one-cycle pulse when the debounced level goes 1→0. Release generates no event. A held key gives exactly one event.
- FSM transitions (start = START event, lap = LAP event):
  - IDLE: start → RUN; lap ignored.
  - RUN: start → PAUSE; lap → LAP.
  - LAP: lap → RUN (unfreeze); start → PAUSE (freeze drops).
  - PAUSE: start → RUN; lap → IDLE with clear pulse.
- Both events in the same cycle: start is taken, lap is discarded.
- Prescaler, 0..DIV-1:
  - Counts only when run = 1.
  - tick = 1 for the cycle in which it is at DIV-1; it wraps to 0 on the next edge.
  - Holds its value in PAUSE, so a resume keeps the fractional tenth.
  - Set to 0 on entry to IDLE and by reset.
- tick is never high while run = 0.
- clear coincides with the transition to IDLE.

## Timing

- Reset values: state=IDLE, run=0, tick=0, clear=0, freeze=0, prescaler=0.
  - Synchronizer flops and debounced levels reset to 1 (released); debounce counters reset to 0.
- Key-to-state latency: exactly DB_CYCLES+3 rising edges from the first edge that samples the key low (2 sync + DB_CYCLES debounce + 1 FSM register), given the key is held stable.
- run, freeze and state are registered and change on the same edge as the FSM state. clear is registered and high for exactly that one cycle.
- First tick after IDLE→RUN: the edge entering RUN counts as prescaler cycle 0, so tick is high on the DIV-th cycle in RUN.
- Key glitches shorter than DB_CYCLES cycles produce no event.
- Reset asserted mid-operation forces all reset values immediately, including a pending clear or a partial debounce. A key held through reset release gives no event until it is released and pressed again.

## Structure

- Shared package `stopwatch_pkg` holds:
  - the state encoding constants (IDLE/RUN/PAUSE/LAP);
  - the DIV and DB_CYCLES derivation functions, also used by the digit-counter bench.
- One sub-module, `key_debounce` (parameter DB_CYCLES; ports clk, reset, key_n, level, press), instantiated twice.
- Prescaler and FSM live in the top level.

## Test plan

Benches use CLK_HZ=1000, TICK_HZ=10, DEBOUNCE_MS=2, giving DIV=100 and DB_CYCLES=2.

- Reset, then hold key_start_n low for 10 cycles → state=RUN exactly 5 edges after the first low sample; run=1. First tick on the 100th cycle in RUN, then every 100 cycles.
- While in RUN, pulse key_start_n low for 1 cycle (glitch) → no state change, ticks continue uninterrupted.
- RUN for 250 cycles, press START → PAUSE, no ticks. Wait 500 cycles, press START → RUN; next tick 50 cycles after re-entry.
- RUN, press LAP → state=LAP, freeze=1, ticks continue. Press LAP again → RUN, freeze=0.
- PAUSE, press LAP → clear high exactly 1 cycle, state=IDLE, prescaler=0. A subsequent START gives the first tick after 100 cycles.
- Press both keys in the same cycle from RUN → PAUSE, no LAP. Assert reset mid-debounce in another run → all outputs 0, state=IDLE, no event after reset release while keys stay held.
